// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control unit: opcodes, FSM states
// and datapath select values.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11,
    S_HALT   = 4'd12
  } state_e;

  localparam logic [1:0] ALUOP_ADD    = 2'b00;
  localparam logic [1:0] ALUOP_SUB    = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT  = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMMSH   = 2'b11;

  function automatic logic is_legal(input logic [5:0] op);
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_J: is_legal = 1'b1;
      default:                                              is_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mc_control_if.sv
// Control-unit <-> datapath bundle; master is the controller, slave the datapath.
interface mc_control_if #(parameter int CNT_W = 32);

  logic [5:0]       opcode;
  logic             zero;
  logic             mem_ready;
  logic             iord;
  logic             memwrite;
  logic             irwrite;
  logic             regdst;
  logic             memtoreg;
  logic             regwrite;
  logic             alusrca;
  logic [1:0]       alusrcb;
  logic [1:0]       aluop;
  logic [1:0]       pcsrc;
  logic             pcen;
  logic             illegal;
  logic             halted;
  logic [CNT_W-1:0] instret;

  modport master (
    input  opcode, zero, mem_ready,
    output iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
           alusrcb, aluop, pcsrc, pcen, illegal, halted, instret
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
           alusrcb, aluop, pcsrc, pcen, illegal, halted, instret
  );

endinterface

// File: rtl/mc_control.sv
// Multicycle MIPS control FSM with memory handshake, bne, illegal-opcode trap
// and retired-instruction counter.
module mc_control
  import mips_pkg::*;
#(
  parameter bit MEM_HANDSHAKE = 1'b1,
  parameter bit TRAP_ILLEGAL  = 1'b0,
  parameter int CNT_W         = 32
) (
  input  logic          clk,
  input  logic          reset,
  mc_control_if.master  bus
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic             retire;
  logic             mr_eff;

  assign mr_eff = MEM_HANDSHAKE ? bus.mem_ready : 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_FETCH;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
    end
  end

  assign instret_d   = retire ? instret_q + 1'b1 : instret_q;
  assign bus.instret = instret_q;

  always_comb begin
    state_d      = state_q;
    retire       = 1'b0;
    bus.iord     = 1'b0;
    bus.memwrite = 1'b0;
    bus.irwrite  = 1'b0;
    bus.regdst   = 1'b0;
    bus.memtoreg = 1'b0;
    bus.regwrite = 1'b0;
    bus.alusrca  = 1'b0;
    bus.alusrcb  = SRCB_REG;
    bus.aluop    = ALUOP_ADD;
    bus.pcsrc    = PCSRC_ALU;
    bus.pcen     = 1'b0;
    bus.illegal  = 1'b0;
    bus.halted   = 1'b0;

    case (state_q)
      S_FETCH: begin
        bus.alusrcb = SRCB_FOUR;
        bus.irwrite = mr_eff;
        bus.pcen    = mr_eff;
        if (mr_eff) state_d = S_DECODE;
      end
      S_DECODE: begin
        bus.alusrcb = SRCB_IMMSH;
        bus.illegal = !is_legal(bus.opcode);
        case (bus.opcode)
          OP_LW, OP_SW:   state_d = S_MEMADR;
          OP_RTYPE:       state_d = S_EXEC;
          OP_BEQ, OP_BNE: state_d = S_BRANCH;
          OP_ADDI:        state_d = S_ADDIEX;
          OP_J:           state_d = S_JUMP;
          default:        state_d = TRAP_ILLEGAL ? S_HALT : S_FETCH;
        endcase
      end
      S_MEMADR: begin
        bus.alusrca = 1'b1;
        bus.alusrcb = SRCB_IMM;
        state_d     = (bus.opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        bus.iord = 1'b1;
        if (mr_eff) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        bus.memtoreg = 1'b1;
        bus.regwrite = 1'b1;
        retire       = 1'b1;
        state_d      = S_FETCH;
      end
      S_MEMWR: begin
        bus.iord     = 1'b1;
        bus.memwrite = mr_eff;
        if (mr_eff) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_EXEC: begin
        bus.alusrca = 1'b1;
        bus.aluop   = ALUOP_FUNCT;
        state_d     = S_ALUWB;
      end
      S_ALUWB: begin
        bus.regdst   = 1'b1;
        bus.regwrite = 1'b1;
        retire       = 1'b1;
        state_d      = S_FETCH;
      end
      S_BRANCH: begin
        bus.alusrca = 1'b1;
        bus.aluop   = ALUOP_SUB;
        bus.pcsrc   = PCSRC_ALUOUT;
        bus.pcen    = (bus.opcode == OP_BNE) ? !bus.zero : bus.zero;
        retire      = 1'b1;
        state_d     = S_FETCH;
      end
      S_ADDIEX: begin
        bus.alusrca = 1'b1;
        bus.alusrcb = SRCB_IMM;
        state_d     = S_ADDIWB;
      end
      S_ADDIWB: begin
        bus.regwrite = 1'b1;
        retire       = 1'b1;
        state_d      = S_FETCH;
      end
      S_JUMP: begin
        bus.pcsrc = PCSRC_JUMP;
        bus.pcen  = 1'b1;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_HALT: begin
        bus.halted = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase

    // Outputs are forced quiet while reset is held, even though state is FETCH.
    if (reset) begin
      bus.iord     = 1'b0;
      bus.memwrite = 1'b0;
      bus.irwrite  = 1'b0;
      bus.regdst   = 1'b0;
      bus.memtoreg = 1'b0;
      bus.regwrite = 1'b0;
      bus.alusrca  = 1'b0;
      bus.alusrcb  = SRCB_REG;
      bus.aluop    = ALUOP_ADD;
      bus.pcsrc    = PCSRC_ALU;
      bus.pcen     = 1'b0;
      bus.illegal  = 1'b0;
      bus.halted   = 1'b0;
    end
  end

endmodule

// File: tb/tb_mc_control.sv
// Self-checking bench for mc_control: per-instruction cycle scripts built from
// the opcode rules, checked against four parameterisations sharing one stimulus.
module tb_mc_control;
  import mips_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] op = 6'd0;
  logic       zr = 1'b0;
  logic       mr = 1'b0;

  always #5 clk = ~clk;

  mc_control_if #(.CNT_W(32)) if_m ();
  mc_control_if #(.CNT_W(32)) if_t ();
  mc_control_if #(.CNT_W(4))  if_c ();
  mc_control_if #(.CNT_W(32)) if_n ();

  assign if_m.opcode = op; assign if_m.zero = zr; assign if_m.mem_ready = mr;
  assign if_t.opcode = op; assign if_t.zero = zr; assign if_t.mem_ready = mr;
  assign if_c.opcode = op; assign if_c.zero = zr; assign if_c.mem_ready = mr;
  assign if_n.opcode = op; assign if_n.zero = zr; assign if_n.mem_ready = mr;

  mc_control #(.MEM_HANDSHAKE(1'b1), .TRAP_ILLEGAL(1'b0), .CNT_W(32)) u_m (.clk(clk), .reset(reset), .bus(if_m));
  mc_control #(.MEM_HANDSHAKE(1'b1), .TRAP_ILLEGAL(1'b1), .CNT_W(32)) u_t (.clk(clk), .reset(reset), .bus(if_t));
  mc_control #(.MEM_HANDSHAKE(1'b1), .TRAP_ILLEGAL(1'b0), .CNT_W(4))  u_c (.clk(clk), .reset(reset), .bus(if_c));
  mc_control #(.MEM_HANDSHAKE(1'b0), .TRAP_ILLEGAL(1'b0), .CNT_W(32)) u_n (.clk(clk), .reset(reset), .bus(if_n));

  wire [15:0] vec_m = {if_m.iord, if_m.memwrite, if_m.irwrite, if_m.regdst, if_m.memtoreg, if_m.regwrite,
                       if_m.alusrca, if_m.alusrcb, if_m.aluop, if_m.pcsrc, if_m.pcen, if_m.illegal, if_m.halted};
  wire [15:0] vec_t = {if_t.iord, if_t.memwrite, if_t.irwrite, if_t.regdst, if_t.memtoreg, if_t.regwrite,
                       if_t.alusrca, if_t.alusrcb, if_t.aluop, if_t.pcsrc, if_t.pcen, if_t.illegal, if_t.halted};
  wire [15:0] vec_c = {if_c.iord, if_c.memwrite, if_c.irwrite, if_c.regdst, if_c.memtoreg, if_c.regwrite,
                       if_c.alusrca, if_c.alusrcb, if_c.aluop, if_c.pcsrc, if_c.pcen, if_c.illegal, if_c.halted};
  wire [15:0] vec_n = {if_n.iord, if_n.memwrite, if_n.irwrite, if_n.regdst, if_n.memtoreg, if_n.regwrite,
                       if_n.alusrca, if_n.alusrcb, if_n.aluop, if_n.pcsrc, if_n.pcen, if_n.illegal, if_n.halted};

  int          sel = 0;
  logic [15:0] vec_sel;
  logic [31:0] cnt_sel;

  always_comb begin
    vec_sel = vec_m;
    cnt_sel = if_m.instret;
    case (sel)
      1: begin vec_sel = vec_t; cnt_sel = if_t.instret; end
      2: begin vec_sel = vec_c; cnt_sel = {28'd0, if_c.instret}; end
      3: begin vec_sel = vec_n; cnt_sel = if_n.instret; end
      default: ;
    endcase
  end

  int          checks = 0;
  int          failures = 0;
  int unsigned model_cnt = 0;
  bit          nh_mode = 1'b0;
  bit          release_pending = 1'b0;
  logic [5:0]  next_op = 6'd0;
  logic        next_zr = 1'b0;
  logic [5:0]  legal_ops [7] = '{OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_J};

  // Bit order: iord memwrite irwrite regdst memtoreg regwrite alusrca alusrcb aluop pcsrc pcen illegal halted
  function automatic logic [15:0] v(input logic io, mw, irw, rd, m2r, rw, sa,
                                    input logic [1:0] sb, ao, ps,
                                    input logic pe, ill, hl);
    return {io, mw, irw, rd, m2r, rw, sa, sb, ao, ps, pe, ill, hl};
  endfunction

  function automatic bit legal_tb(input logic [5:0] o);
    for (int i = 0; i < 7; i++) if (legal_ops[i] == o) return 1'b1;
    return 1'b0;
  endfunction

  task automatic check_now(input logic [15:0] exp, input string tag);
    logic [31:0] ec;
    ec = (sel == 2) ? (model_cnt & 32'hF) : model_cnt;
    checks++;
    assert (vec_sel === exp) else begin
      failures++;
      $error("FAIL %s outputs observed=%h expected=%h sel=%0d", tag, vec_sel, exp, sel);
    end
    checks++;
    assert (cnt_sel === ec) else begin
      failures++;
      $error("FAIL %s instret observed=%0d expected=%0d sel=%0d", tag, cnt_sel, ec, sel);
    end
  endtask

  // mr_v: 0/1 drive that level, 2 = don't care (random)
  task automatic cyc(input int mr_v, input logic [15:0] exp, input bit load, input string tag);
    @(negedge clk);
    if (release_pending) begin reset = 1'b0; release_pending = 1'b0; end
    if (load) begin op = next_op; zr = next_zr; end
    mr = (nh_mode || mr_v == 2) ? 1'($urandom_range(0, 1)) : 1'(mr_v);
    #1;
    check_now(exp, tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    mr = 1'($urandom_range(0, 1));
    model_cnt = 0;
    #1;
    check_now(16'h0, "reset_async");
    @(negedge clk);
    mr = 1'b1;
    #1;
    check_now(16'h0, "reset_held");
    release_pending = 1'b1;
  endtask

  task automatic run_instr(input logic [5:0] o, input logic z, input int fw, input int mw, input bit trap);
    bit legal;
    legal   = legal_tb(o);
    next_op = o;
    next_zr = z;
    for (int i = 0; i < fw; i++) cyc(0, v(0,0,0,0,0,0,0, SRCB_FOUR, 2'b00, 2'b00, 0,0,0), i == 0, "fetch_wait");
    cyc(1, v(0,0,1,0,0,0,0, SRCB_FOUR, 2'b00, 2'b00, 1,0,0), fw == 0, "fetch");
    cyc(2, v(0,0,0,0,0,0,0, SRCB_IMMSH, 2'b00, 2'b00, 0, !legal, 0), 1'b0, "decode");
    if (o == OP_LW) begin
      cyc(2, v(0,0,0,0,0,0,1, SRCB_IMM, 2'b00, 2'b00, 0,0,0), 1'b0, "lw_memadr");
      for (int i = 0; i < mw; i++) cyc(0, v(1,0,0,0,0,0,0, 2'b00, 2'b00, 2'b00, 0,0,0), 1'b0, "lw_memrd_wait");
      cyc(1, v(1,0,0,0,0,0,0, 2'b00, 2'b00, 2'b00, 0,0,0), 1'b0, "lw_memrd");
      cyc(2, v(0,0,0,0,1,1,0, 2'b00, 2'b00, 2'b00, 0,0,0), 1'b0, "lw_memwb");
      model_cnt++;
    end else if (o == OP_SW) begin
      cyc(2, v(0,0,0,0,0,0,1, SRCB_IMM, 2'b00, 2'b00, 0,0,0), 1'b0, "sw_memadr");
      for (int i = 0; i < mw; i++) cyc(0, v(1,0,0,0,0,0,0, 2'b00, 2'b00, 2'b00, 0,0,0), 1'b0, "sw_memwr_wait");
      cyc(1, v(1,1,0,0,0,0,0, 2'b00, 2'b00, 2'b00, 0,0,0), 1'b0, "sw_memwr");
      model_cnt++;
    end else if (o == OP_RTYPE) begin
      cyc(2, v(0,0,0,0,0,0,1, 2'b00, ALUOP_FUNCT, 2'b00, 0,0,0), 1'b0, "r_exec");
      cyc(2, v(0,0,0,1,0,1,0, 2'b00, 2'b00, 2'b00, 0,0,0), 1'b0, "r_aluwb");
      model_cnt++;
    end else if (o == OP_ADDI) begin
      cyc(2, v(0,0,0,0,0,0,1, SRCB_IMM, 2'b00, 2'b00, 0,0,0), 1'b0, "addi_ex");
      cyc(2, v(0,0,0,0,0,1,0, 2'b00, 2'b00, 2'b00, 0,0,0), 1'b0, "addi_wb");
      model_cnt++;
    end else if (o == OP_BEQ || o == OP_BNE) begin
      cyc(2, v(0,0,0,0,0,0,1, 2'b00, ALUOP_SUB, PCSRC_ALUOUT, (o == OP_BEQ) ? z : !z, 0,0), 1'b0, "branch");
      model_cnt++;
    end else if (o == OP_J) begin
      cyc(2, v(0,0,0,0,0,0,0, 2'b00, 2'b00, PCSRC_JUMP, 1,0,0), 1'b0, "jump");
      model_cnt++;
    end else if (trap) begin
      for (int i = 0; i < 20; i++) cyc(2, v(0,0,0,0,0,0,0, 2'b00, 2'b00, 2'b00, 0,0,1), 1'b0, "halt");
    end
  endtask

  function automatic logic [5:0] rand_op(input bit allow_illegal);
    logic [5:0] o;
    if (allow_illegal && $urandom_range(0, 7) == 0) begin
      o = 6'($urandom);
      if (legal_tb(o)) o = 6'b111110;
    end else begin
      o = legal_ops[$urandom_range(0, 6)];
    end
    return o;
  endfunction

  initial begin
    // Main configuration: directed cases first
    sel = 0;
    do_reset();
    run_instr(OP_LW,  1'b0, 0, 0, 1'b0);
    run_instr(OP_SW,  1'b0, 3, 2, 1'b0);
    run_instr(OP_BEQ, 1'b1, 0, 0, 1'b0);
    run_instr(OP_BNE, 1'b1, 0, 0, 1'b0);
    run_instr(OP_BNE, 1'b0, 0, 0, 1'b0);
    run_instr(6'b111111, 1'b0, 0, 0, 1'b0);
    run_instr(OP_J,   1'b0, 1, 0, 1'b0);
    for (int n = 0; n < 40; n++)
      run_instr(rand_op(1'b1), 1'($urandom_range(0, 1)), $urandom_range(0, 2), $urandom_range(0, 2), 1'b0);

    // Reset while waiting in MEMRD with seven instructions retired
    do_reset();
    for (int n = 0; n < 7; n++)
      run_instr(rand_op(1'b0), 1'($urandom_range(0, 1)), $urandom_range(0, 1), $urandom_range(0, 1), 1'b0);
    next_op = OP_LW;
    cyc(1, v(0,0,1,0,0,0,0, SRCB_FOUR, 2'b00, 2'b00, 1,0,0), 1'b1, "mid_fetch");
    cyc(2, v(0,0,0,0,0,0,0, SRCB_IMMSH, 2'b00, 2'b00, 0,0,0), 1'b0, "mid_decode");
    cyc(2, v(0,0,0,0,0,0,1, SRCB_IMM, 2'b00, 2'b00, 0,0,0), 1'b0, "mid_memadr");
    cyc(0, v(1,0,0,0,0,0,0, 2'b00, 2'b00, 2'b00, 0,0,0), 1'b0, "mid_memrd_wait");
    do_reset();
    run_instr(OP_ADDI, 1'b0, 0, 0, 1'b0);

    // Trapping configuration
    sel = 1;
    do_reset();
    run_instr(6'b111111, 1'b0, 0, 0, 1'b1);
    do_reset();
    cyc(0, v(0,0,0,0,0,0,0, SRCB_FOUR, 2'b00, 2'b00, 0,0,0), 1'b0, "trap_refetch");

    // Narrow counter wraps after 16 retirements
    sel = 2;
    do_reset();
    for (int n = 0; n < 17; n++) run_instr(OP_J, 1'b0, 0, 0, 1'b0);
    cyc(0, v(0,0,0,0,0,0,0, SRCB_FOUR, 2'b00, 2'b00, 0,0,0), 1'b0, "cnt4_wrap");

    // Handshake disabled: mem_ready is noise, waveforms must match ready-high
    sel = 3;
    nh_mode = 1'b1;
    do_reset();
    for (int n = 0; n < 15; n++)
      run_instr(rand_op(1'b1), 1'($urandom_range(0, 1)), 0, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mc_control.md
# mc_control

Multicycle MIPS control unit: a Moore-style FSM, with a few outputs qualified by inputs, that sequences one instruction over 3–5+ cycles through a shared memory/ALU datapath. It sits between the instruction register (opcode) and the multicycle datapath, and replaces the single-cycle combinational decoder. Beyond the single-cycle decoder it adds:

- a variable-latency memory handshake;
- `bne` support with internal PC-enable generation;
- illegal-opcode detection with optional trap;
- a retired-instruction counter.

## Interface

Parameters:
- `MEM_HANDSHAKE`, 1: when 1, FETCH/MEMRD/MEMWR wait on `mem_ready`; when 0, `mem_ready` is ignored and treated as 1.
- `TRAP_ILLEGAL`, 0: when 1, an illegal opcode enters HALT; when 0, it returns to FETCH.
- `CNT_W`, 32: width of `instret`.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `opcode` in 6: IR[31:26], stable from end of FETCH until next FETCH.
- `zero` in 1: ALU zero flag.
- `mem_ready` in 1: memory access completes this cycle.
- `iord`, `memwrite`, `irwrite`, `regdst`, `memtoreg`, `regwrite`, `alusrca` out 1: datapath controls.
- `alusrcb`, `aluop`, `pcsrc` out 2: datapath selects.
- `pcen` out 1: PC write enable.
- `illegal` out 1: high during DECODE when the opcode is unsupported.
- `halted` out 1: high in HALT.
- `instret` out CNT_W: count of retired instructions.

## Operation

Supported opcodes:
- R-type `000000`
- `lw` `100011`
- `sw` `101011`
- `beq` `000100`
- `bne` `000101`
- `addi` `001000`
- `j` `000010`

All other opcodes are illegal.

Outputs not listed for a state are 0.

States and their outputs:
- FETCH: `alusrcb`=01, `irwrite`=`pcen`=`mem_ready`.
- DECODE: `alusrcb`=11.
- MEMADR: `alusrca`=1, `alusrcb`=10.
- MEMRD: `iord`=1.
- MEMWB: `memtoreg`=1, `regwrite`=1.
- MEMWR: `iord`=1, `memwrite`=`mem_ready`.
- EXEC: `alusrca`=1, `aluop`=10.
- ALUWB: `regdst`=1, `regwrite`=1.
- BRANCH: `alusrca`=1, `aluop`=01, `pcsrc`=01, `pcen`=`zero` for `beq` and `~zero` for `bne`.
- ADDIEX: `alusrca`=1, `alusrcb`=10.
- ADDIWB: `regwrite`=1.
- JUMP: `pcsrc`=10, `pcen`=1.
- HALT: all controls 0, `halted`=1.

Transitions:
- FETCH→DECODE on `mem_ready`, otherwise hold.
- DECODE→ by opcode:
  - `lw`/`sw` → MEMADR
  - R-type → EXEC
  - `beq`/`bne` → BRANCH
  - `addi` → ADDIEX
  - `j` → JUMP
  - illegal → HALT if `TRAP_ILLEGAL`, else FETCH
- MEMADR → MEMRD (`lw`) or MEMWR (`sw`).
- MEMRD → MEMWB on `mem_ready`, otherwise hold.
- MEMWR → FETCH on `mem_ready`, otherwise hold.
- EXEC → ALUWB.
- ADDIEX → ADDIWB.
- MEMWB, ALUWB, ADDIWB, BRANCH, JUMP → FETCH.
- HALT → HALT until `reset`.

`instret`:
- Increments by 1 on each clock edge leaving MEMWB, MEMWR (with `mem_ready`), ALUWB, ADDIWB, BRANCH or JUMP.
- Wraps modulo 2^CNT_W.
- Illegal instructions do not count.

## Timing

- Reset (asynchronous): state=FETCH, `instret`=0.
  - While `reset` is high, all outputs are forced 0, including `irwrite`/`pcen`, regardless of `mem_ready`.
  - After release, FETCH outputs apply.
- Cycle counts with `mem_ready` tied high:
  - `lw` 5, `sw` 4, R-type 4, `addi` 4, `beq`/`bne` 3, `j` 3.
  - Illegal: 2 (non-trap).
- Each low `mem_ready` cycle in FETCH, MEMRD or MEMWR adds exactly one cycle.
  - `irwrite`, `pcen` and `memwrite` are never high on a cycle where `mem_ready`=0.
- A one-cycle `mem_ready` pulse must be honoured.
- With `MEM_HANDSHAKE`=0, waveforms equal the `mem_ready`=1 case.
- `pcen` and `memwrite` go high at most once per instruction.
- `reset` asserted in any state, including HALT or mid-wait, returns to FETCH on the next evaluation.
- The counter increment in flight at that edge is discarded.

## Structure

- Shared package `mips_pkg`:
  - opcode constants (`OP_RTYPE`, `OP_LW`, `OP_SW`, `OP_BEQ`, `OP_BNE`, `OP_ADDI`, `OP_J`);
  - 4-bit state encoding constants for the 13 states;
  - `aluop`/`pcsrc`/`alusrcb` encodings.
- Single module. The state register, next-state logic, output decode and counter are all inline; no sub-module is needed.

## Test plan

- Reset mid-stream in MEMRD with `instret`=7 → state FETCH, `instret`=0, all outputs 0 while `reset`=1.
- `lw` (`100011`), `mem_ready`=1 → states FETCH, DECODE, MEMADR, MEMRD, MEMWB over 5 cycles; `regwrite`=1 and `memtoreg`=1 in cycle 5; `instret` 0→1.
- `sw` with `mem_ready` low for 3 cycles in FETCH and 2 in MEMWR → 9 total cycles; `memwrite` high exactly 1 cycle, coincident with `mem_ready`.
- `beq` with `zero`=1 → `pcen`=1, `pcsrc`=01 in cycle 3. `bne` with `zero`=1 → `pcen`=0. `bne` with `zero`=0 → `pcen`=1.
- Opcode `111111` with `TRAP_ILLEGAL`=0 → `illegal`=1 for 1 cycle, back to FETCH, `instret` unchanged. With `TRAP_ILLEGAL`=1 → `halted`=1 held for 20 cycles until `reset`.
- `CNT_W`=4: retire 17 `j` instructions → `instret`=1; each `j` takes 3 cycles with `pcsrc`=10 and `pcen`=1 in cycle 3.
